// File: rtl/trace_buffer.sv
// Write-back trace capture: circular buffer of {timestamp, pc, reg, data} entries,
// frozen by a PC-match trigger plus post-trigger count, then drained oldest-first.
module trace_buffer #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              trig_en_i,
    input  logic [PC_W-1:0]   trig_pc_i,
    input  logic [AW-1:0]     post_cnt_i,
    input  logic              cap_en_i,
    input  logic [PC_W-1:0]   cap_pc_i,
    input  logic [REG_W-1:0]  cap_reg_i,
    input  logic [DATA_W-1:0] cap_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [TS_W-1:0]   rd_ts_o,
    output logic [PC_W-1:0]   rd_pc_o,
    output logic [REG_W-1:0]  rd_reg_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CW-1:0]     count_o,
    output logic [1:0]        state_o,
    output logic              triggered_o
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_POST   = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;
    localparam int EW = TS_W + PC_W + REG_W + DATA_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   rd_entry;
    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   post_lat_q, post_lat_d, remain_q, remain_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            triggered_q, triggered_d;
    logic            capturing, trig_hit, rd_fire;

    assign capturing = cap_en_i && !arm_i && (state_q == ST_ARMED || state_q == ST_POST);
    assign trig_hit  = (state_q == ST_ARMED) && trig_en_i && cap_en_i && (cap_pc_i == trig_pc_i);
    assign rd_valid_o = (state_q == ST_FROZEN) && (count_q != '0);
    assign rd_fire    = rd_valid_o && rd_ready_i;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        post_lat_d  = post_lat_q;
        remain_d    = remain_q;
        ts_d        = ts_q;
        triggered_d = triggered_q;
        if (arm_i) begin
            state_d     = ST_ARMED;
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            ts_d        = '0;
            triggered_d = 1'b0;
            post_lat_d  = post_cnt_i;
        end else begin
            if (state_q == ST_ARMED || state_q == ST_POST)
                ts_d = ts_q + TS_W'(1);
            // Once full, each new write evicts the oldest entry, so rptr follows wptr.
            if (capturing) begin
                wptr_d = wptr_q + AW'(1);
                if (count_q == FULL_CNT)
                    rptr_d = rptr_q + AW'(1);
                else
                    count_d = count_q + CW'(1);
            end
            case (state_q)
                ST_ARMED: begin
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        if (post_lat_q == '0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            state_d  = ST_POST;
                            remain_d = post_lat_q;
                        end
                    end
                end
                ST_POST: begin
                    if (cap_en_i) begin
                        remain_d = remain_q - AW'(1);
                        if (remain_q == AW'(1))
                            state_d = ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (rd_fire) begin
                        rptr_d  = rptr_q + AW'(1);
                        count_d = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            post_lat_q  <= '0;
            remain_q    <= '0;
            ts_q        <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            post_lat_q  <= post_lat_d;
            remain_q    <= remain_d;
            ts_q        <= ts_d;
            triggered_q <= triggered_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capturing)
            mem_q[wptr_q] <= {ts_q, cap_pc_i, cap_reg_i, cap_data_i};
    end

    // Read data is gated so every output is zero while nothing is offered.
    assign rd_entry = rd_valid_o ? mem_q[rptr_q] : '0;
    assign {rd_ts_o, rd_pc_o, rd_reg_o, rd_data_o} = rd_entry;
    assign count_o     = count_q;
    assign state_o     = state_q;
    assign triggered_o = triggered_q;
endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus randomized rounds,
// compared every cycle against a queue-based reference model.
module tb_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm_i = 1'b0, trig_en_i = 1'b0, cap_en_i = 1'b0, rd_ready_i = 1'b0;
    logic [31:0] trig_pc_i = '0, cap_pc_i = '0, cap_data_i = '0;
    logic [3:0]  post_cnt_i = '0, cap_reg_i = '0;
    logic        rd_valid_o, triggered_o;
    logic [15:0] rd_ts_o;
    logic [31:0] rd_pc_o, rd_data_o;
    logic [3:0]  rd_reg_o;
    logic [4:0]  count_o;
    logic [1:0]  state_o;

    trace_buffer dut (
        .clk(clk), .rst(rst), .arm_i(arm_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
        .post_cnt_i(post_cnt_i), .cap_en_i(cap_en_i), .cap_pc_i(cap_pc_i),
        .cap_reg_i(cap_reg_i), .cap_data_i(cap_data_i), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .rd_ts_o(rd_ts_o), .rd_pc_o(rd_pc_o), .rd_reg_o(rd_reg_o),
        .rd_data_o(rd_data_o), .count_o(count_o), .state_o(state_o), .triggered_o(triggered_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ts;
        logic [31:0] pc;
        logic [3:0]  rg;
        logic [31:0] data;
    } ent_t;

    // Reference model: held entries as a queue, oldest at the front.
    ent_t        m_q[$];
    int          m_state;
    logic [15:0] m_ts;
    logic        m_trig;
    int          m_post, m_remain;
    int          n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = 0; m_ts = '0; m_trig = 1'b0; m_post = 0; m_remain = 0;
    endtask

    task automatic model_capture();
        ent_t e;
        e.ts = m_ts; e.pc = cap_pc_i; e.rg = cap_reg_i; e.data = cap_data_i;
        m_q.push_back(e);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endtask

    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (arm_i) begin
            m_q.delete(); m_ts = '0; m_trig = 1'b0; m_state = 1; m_post = int'(post_cnt_i);
        end else if (m_state == 1) begin
            if (cap_en_i) model_capture();
            m_ts = m_ts + 16'd1;
            if (trig_en_i && cap_en_i && cap_pc_i == trig_pc_i) begin
                m_trig = 1'b1;
                if (m_post == 0) m_state = 3;
                else begin m_state = 2; m_remain = m_post; end
            end
        end else if (m_state == 2) begin
            if (cap_en_i) begin
                model_capture();
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
            m_ts = m_ts + 16'd1;
        end else if (m_state == 3) begin
            if (rd_ready_i && m_q.size() != 0) void'(m_q.pop_front());
        end
    endtask

    task automatic compare_all();
        logic mv;
        mv = (m_state == 3) && (m_q.size() != 0);
        check("state", 64'(state_o), 64'(m_state));
        check("count", 64'(count_o), 64'(m_q.size()));
        check("triggered", 64'(triggered_o), 64'(m_trig));
        check("rd_valid", 64'(rd_valid_o), 64'(mv));
        if (mv) begin
            check("rd_ts", 64'(rd_ts_o), 64'(m_q[0].ts));
            check("rd_pc", 64'(rd_pc_o), 64'(m_q[0].pc));
            check("rd_reg", 64'(rd_reg_o), 64'(m_q[0].rg));
            check("rd_data", 64'(rd_data_o), 64'(m_q[0].data));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_arm(input logic [3:0] post, input logic [31:0] tpc, input logic ten);
        arm_i = 1'b1; post_cnt_i = post; trig_pc_i = tpc; trig_en_i = ten;
        tick();
        arm_i = 1'b0; post_cnt_i = ~post;
    endtask

    task automatic do_cap(input logic [31:0] pc, input logic [31:0] data);
        cap_en_i = 1'b1; cap_pc_i = pc; cap_data_i = data; cap_reg_i = data[3:0];
        tick();
        cap_en_i = 1'b0;
    endtask

    initial begin
        int ready_pat[6];
        int cnt_pat[6];
        ready_pat = '{1, 0, 0, 1, 1, 1};
        cnt_pat   = '{3, 3, 3, 2, 1, 0};
        model_reset();

        // Reset held, then capture strobes without arm are ignored.
        repeat (5) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_cap(32'h10 + 32'(i), 32'(i));
            check("idle_count", 64'(count_o), 64'd0);
        end

        // Basic capture and in-order drain.
        do_arm(4'd0, 32'h0C, 1'b1);
        for (int i = 0; i < 4; i++) do_cap(32'(4 * i), 32'hA0 + 32'(i));
        check("basic_frozen", 64'(state_o), 64'd3);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("basic_pc", 64'(rd_pc_o), 64'(4 * i));
            check("basic_ts", 64'(rd_ts_o), 64'(i));
            tick();
        end
        check("basic_empty", 64'(rd_valid_o), 64'd0);
        rd_ready_i = 1'b0;

        // Wrap-around: 20 captures into 16 entries, trigger on 18, post count 2.
        do_arm(4'd2, 32'h100 + 32'd18, 1'b1);
        for (int i = 1; i <= 20; i++) do_cap(32'h100 + 32'(i), 32'(i));
        check("wrap_count", 64'(count_o), 64'd16);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("wrap_data", 64'(rd_data_o), 64'(5 + i));
            tick();
        end
        rd_ready_i = 1'b0;

        // Backpressure on a 4-entry frozen buffer.
        do_arm(4'd0, 32'h40, 1'b1);
        for (int i = 0; i < 4; i++) do_cap(32'h34 + 32'(4 * i), 32'h50 + 32'(i));
        check("bp_count0", 64'(count_o), 64'd4);
        for (int i = 0; i < 6; i++) begin
            rd_ready_i = ready_pat[i][0];
            tick();
            check("bp_count", 64'(count_o), 64'(cnt_pat[i]));
        end
        rd_ready_i = 1'b0;

        // Re-arm mid-readout with a concurrent read handshake.
        do_arm(4'd0, 32'h80, 1'b1);
        for (int i = 0; i < 8; i++) do_cap(32'h64 + 32'(4 * i), 32'h70 + 32'(i));
        rd_ready_i = 1'b1;
        repeat (3) tick();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0; rd_ready_i = 1'b0;
        check("rearm_state", 64'(state_o), 64'd1);
        check("rearm_count", 64'(count_o), 64'd0);
        check("rearm_trig", 64'(triggered_o), 64'd0);
        // The first capture after re-arm must carry timestamp 0.
        trig_pc_i = 32'h200;
        do_cap(32'h200, 32'h99);
        check("rearm_ts", 64'(rd_ts_o), 64'd0);

        // Async reset between edges during POST.
        do_arm(4'd5, 32'h20, 1'b1);
        do_cap(32'h20, 32'h1);
        do_cap(32'h24, 32'h2);
        check("post_state", 64'(state_o), 64'd2);
        #3 rst = 1'b0;
        #1 model_reset();
        compare_all();
        tick();
        rst = 1'b1;

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            do_arm(4'($urandom_range(0, 15)), 32'(4 * $urandom_range(0, 7)), ($urandom_range(0, 7) != 0));
            for (int c = 0; c < 150; c++) begin
                cap_en_i   = ($urandom_range(0, 3) != 0);
                cap_pc_i   = 32'(4 * $urandom_range(0, 7));
                cap_reg_i  = 4'($urandom);
                cap_data_i = $urandom;
                rd_ready_i = ($urandom_range(0, 2) != 0);
                arm_i      = ($urandom_range(0, 99) == 0);
                if (arm_i) post_cnt_i = 4'($urandom);
                tick();
                arm_i = 1'b0;
                if (m_state == 3 && m_q.size() == 0) break;
            end
            cap_en_i = 1'b0; rd_ready_i = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
